// File: rtl/disp_pkg.sv
// Shared types for the multiplexed seven-segment scan controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package disp_pkg;

    localparam int DIGITS_MAX = 8;

    typedef logic [3:0] nibble_t;

    typedef enum logic {
        BLANK = 1'b0,
        DRIVE = 1'b1
    } scan_state_t;

endpackage

// File: rtl/scan_timer.sv
// Dwell counter: counts 0..tc, pulses expire on the cycle the count reaches tc.
// Latency: expire is combinational from the count; the count restarts at 0 after expiry.
// Backpressure: none, free-running.
// Ports: clk, reset (sync, active-high), tc (terminal count for the current dwell), expire.
module scan_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] tc,
    output logic         expire
);

    logic [W-1:0] cnt;

    assign expire = (cnt == tc);

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (expire) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/display_scan_ctrl.sv
// Multiplexed digit scanner: BLANK gap then DRIVE dwell per digit, double-buffered frames.
// Latency: all outputs registered; a loaded frame appears at the next frame boundary.
// Backpressure: load_ready drops while the one-entry pending buffer is full.
// Ports: clk, reset (sync, active-high), load_valid/load_ready/load_data/load_blank frame
// input, dec_val (to external seven_seg), dig_en (one-hot digit select), frame_done pulse.
// Optional macro DISPLAY_SCAN_BLINK_EN adds load_blink and parameter BLINK_FRAMES.
module display_scan_ctrl
    import disp_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int SCAN_DIV   = 1000,
    parameter int BLANK_CYC  = 2
`ifdef DISPLAY_SCAN_BLINK_EN
    ,parameter int BLINK_FRAMES = 32
`endif
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    load_valid,
    output logic                    load_ready,
    input  logic [4*NUM_DIGITS-1:0] load_data,
    input  logic [NUM_DIGITS-1:0]   load_blank,
`ifdef DISPLAY_SCAN_BLINK_EN
    input  logic [NUM_DIGITS-1:0]   load_blink,
`endif
    output logic [3:0]              dec_val,
    output logic [NUM_DIGITS-1:0]   dig_en,
    output logic                    frame_done
);

    localparam int IDX_W     = $clog2(NUM_DIGITS);
    localparam int DWELL_MAX = (SCAN_DIV > BLANK_CYC) ? SCAN_DIV : BLANK_CYC;
    localparam int TW        = $clog2(DWELL_MAX) + 1;
    localparam logic [IDX_W-1:0]      IDX_LAST = IDX_W'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] DIG0     = NUM_DIGITS'(1);

    scan_state_t state, state_nxt;
    logic [IDX_W-1:0] idx, idx_nxt;
    logic [TW-1:0]    tc;
    logic             expire;
    logic             boundary;
    logic             accept;
    logic             apply;

    nibble_t [NUM_DIGITS-1:0] act_nib, pend_nib, act_nib_nxt;
    logic [NUM_DIGITS-1:0]    act_blank, pend_blank, act_blank_nxt;
    logic                     pend_vld;
    logic [NUM_DIGITS-1:0]    dark_nxt;
    logic [3:0]               dec_val_nxt;
    logic [NUM_DIGITS-1:0]    dig_en_nxt;

    // Terminal count for the dwell of the state currently being held.
    assign tc = (state == BLANK) ? TW'(BLANK_CYC - 1) : TW'(SCAN_DIV - 1);

    scan_timer #(.W(TW)) u_timer (
        .clk    (clk),
        .reset  (reset),
        .tc     (tc),
        .expire (expire)
    );

    assign load_ready = ~pend_vld;
    assign accept     = load_valid & ~pend_vld;
    assign boundary   = (state == DRIVE) && expire && (idx == IDX_LAST);
    // Pending is only promoted at a frame boundary so the active frame never changes mid-scan.
    assign apply      = boundary & pend_vld;

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        if (expire) begin
            if (state == BLANK) begin
                state_nxt = DRIVE;
            end else begin
                state_nxt = BLANK;
                idx_nxt   = (idx == IDX_LAST) ? '0 : idx + 1'b1;
            end
        end
    end

    assign act_nib_nxt   = apply ? pend_nib   : act_nib;
    assign act_blank_nxt = apply ? pend_blank : act_blank;

`ifdef DISPLAY_SCAN_BLINK_EN
    localparam int BW = $clog2(BLINK_FRAMES) + 1;
    logic [NUM_DIGITS-1:0] act_blink, pend_blink, act_blink_nxt;
    logic [BW-1:0]         blink_cnt, blink_cnt_nxt;
    logic                  blink_phase, blink_phase_nxt;

    assign act_blink_nxt = apply ? pend_blink : act_blink;

    always_comb begin
        blink_cnt_nxt   = blink_cnt;
        blink_phase_nxt = blink_phase;
        if (boundary) begin
            if (blink_cnt == BW'(BLINK_FRAMES - 1)) begin
                blink_cnt_nxt   = '0;
                blink_phase_nxt = ~blink_phase;
            end else begin
                blink_cnt_nxt = blink_cnt + 1'b1;
            end
        end
    end

    assign dark_nxt = act_blank_nxt | (blink_phase_nxt ? act_blink_nxt : '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            act_blink   <= '0;
            pend_blink  <= '0;
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else begin
            act_blink   <= act_blink_nxt;
            blink_cnt   <= blink_cnt_nxt;
            blink_phase <= blink_phase_nxt;
            if (accept) begin
                pend_blink <= load_blink;
            end
        end
    end
`else
    assign dark_nxt = act_blank_nxt;
`endif

    // Output decode from next-cycle values, so the registered outputs line up with the state.
    always_comb begin
        dec_val_nxt = act_nib_nxt[idx_nxt];
        dig_en_nxt  = '0;
        if ((state_nxt == DRIVE) && !dark_nxt[idx_nxt]) begin
            dig_en_nxt = DIG0 << idx_nxt;
        end
    end

    // State, buffers and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= BLANK;
            idx        <= '0;
            act_nib    <= '0;
            act_blank  <= '1;
            pend_nib   <= '0;
            pend_blank <= '1;
            pend_vld   <= 1'b0;
            dec_val    <= '0;
            dig_en     <= '0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_nxt;
            idx        <= idx_nxt;
            act_nib    <= act_nib_nxt;
            act_blank  <= act_blank_nxt;
            // accept needs pend_vld low and apply needs it high, so they never collide.
            pend_vld   <= accept | (pend_vld & ~boundary);
            if (accept) begin
                pend_nib   <= load_data;
                pend_blank <= load_blank;
            end
            dec_val    <= dec_val_nxt;
            dig_en     <= dig_en_nxt;
            frame_done <= boundary;
        end
    end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Directed bench for display_scan_ctrl with NUM_DIGITS=4, SCAN_DIV=4, BLANK_CYC=1 (20-cycle frames).
// Cycle 0 is the first cycle after the reset edge; frame boundaries land at cycles 19, 39, ...
// Outputs are sampled 1 time unit after the rising edge; inputs change at the same point.
module tb_display_scan_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        load_valid;
    logic        load_ready;
    logic [15:0] load_data;
    logic [3:0]  load_blank;
    logic [3:0]  dec_val;
    logic [3:0]  dig_en;
    logic        frame_done;

    int vectors = 0;
    int errs    = 0;

    always #5 clk = ~clk;

    display_scan_ctrl #(
        .NUM_DIGITS (4),
        .SCAN_DIV   (4),
        .BLANK_CYC  (1)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_data  (load_data),
        .load_blank (load_blank),
        .dec_val    (dec_val),
        .dig_en     (dig_en),
        .frame_done (frame_done)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Checks one full frame starting at its first cycle (frame_done high).
    // After the first cycle, the load inputs switch to nv/nd/nb; rdy1 is load_ready expected then.
    task automatic run_frame(input logic [15:0] nib, input logic [3:0] blk,
                             input logic nv, input logic [15:0] nd, input logic [3:0] nb,
                             input logic rdy1);
        int d;
        logic [3:0] exp_dec;
        logic [3:0] exp_en;
        for (int off = 0; off < 20; off++) begin
            d       = off / 5;
            exp_dec = nib[4*d +: 4];
            exp_en  = ((off % 5) != 0 && !blk[d]) ? 4'(1 << d) : 4'b0;
            chk($sformatf("frame %04h off %0d dig_en", nib, off), 16'(dig_en), 16'(exp_en));
            chk($sformatf("frame %04h off %0d dec_val", nib, off), 16'(dec_val), 16'(exp_dec));
            chk($sformatf("frame %04h off %0d frame_done", nib, off), 16'(frame_done), 16'(off == 0));
            if (off == 1) begin
                chk($sformatf("frame %04h load_ready", nib), 16'(load_ready), 16'(rdy1));
            end
            tick();
            if (off == 0) begin
                load_valid = nv;
                load_data  = nd;
                load_blank = nb;
            end
        end
    endtask

    initial begin
        reset      = 1'b1;
        load_valid = 1'b0;
        load_data  = 16'h0;
        load_blank = 4'h0;
        tick();
        tick();
        reset = 1'b0;

        // Reset state.
        chk("reset dig_en", 16'(dig_en), 16'h0);
        chk("reset dec_val", 16'(dec_val), 16'h0);
        chk("reset frame_done", 16'(frame_done), 16'h0);
        chk("reset load_ready", 16'(load_ready), 16'h1);

        // Idle: dark display, frame_done at cycles 20 and 40.
        for (int k = 0; k <= 40; k++) begin
            chk($sformatf("idle c%0d dig_en", k), 16'(dig_en), 16'h0);
            chk($sformatf("idle c%0d frame_done", k), 16'(frame_done), 16'(k == 20 || k == 40));
            chk($sformatf("idle c%0d load_ready", k), 16'(load_ready), 16'h1);
            if (k < 40) tick();
        end

        // Cycle 40: load 0x4321; must not show until the boundary after cycle 59.
        load_valid = 1'b1;
        load_data  = 16'h4321;
        load_blank = 4'h0;
        tick();
        load_valid = 1'b0;
        chk("after load 4321 load_ready", 16'(load_ready), 16'h0);
        for (int k = 41; k < 60; k++) begin
            chk($sformatf("pre-4321 c%0d dig_en", k), 16'(dig_en), 16'h0);
            tick();
        end
        chk("c60 load_ready", 16'(load_ready), 16'h1);
        run_frame(16'h4321, 4'h0, 1'b0, 16'h0, 4'h0, 1'b1);

        // Cycle 80: 0x1111 accepted now; 0x2222 held valid, accepted at cycle 100.
        load_valid = 1'b1;
        load_data  = 16'h1111;
        load_blank = 4'h0;
        run_frame(16'h4321, 4'h0, 1'b1, 16'h2222, 4'h0, 1'b0);
        chk("c100 load_ready", 16'(load_ready), 16'h1);
        run_frame(16'h1111, 4'h0, 1'b0, 16'h0, 4'h0, 1'b0);

        // Cycle 120: 0x2222 shown; queue 0x9876 with digit 2 blanked, then 0x5555 held.
        load_valid = 1'b1;
        load_data  = 16'h9876;
        load_blank = 4'h4;
        run_frame(16'h2222, 4'h0, 1'b1, 16'h5555, 4'h0, 1'b0);
        run_frame(16'h9876, 4'h4, 1'b0, 16'h0, 4'h0, 1'b0);

        // Cycle 160: 0x5555 active; fill pending with 0xAAAA, reset mid-DRIVE of digit 2.
        chk("c160 load_ready", 16'(load_ready), 16'h1);
        load_valid = 1'b1;
        load_data  = 16'hAAAA;
        tick();
        load_valid = 1'b0;
        chk("c161 load_ready", 16'(load_ready), 16'h0);
        for (int k = 161; k < 172; k++) tick();
        chk("c172 dig_en", 16'(dig_en), 16'h4);
        chk("c172 dec_val", 16'(dec_val), 16'h5);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("post-reset dig_en", 16'(dig_en), 16'h0);
        chk("post-reset dec_val", 16'(dec_val), 16'h0);
        chk("post-reset frame_done", 16'(frame_done), 16'h0);
        chk("post-reset load_ready", 16'(load_ready), 16'h1);

        // Pending was discarded: dark frame, then a load on the boundary cycle itself.
        for (int k = 0; k < 20; k++) begin
            chk($sformatf("rst c%0d dig_en", k), 16'(dig_en), 16'h0);
            chk($sformatf("rst c%0d dec_val", k), 16'(dec_val), 16'h0);
            chk($sformatf("rst c%0d frame_done", k), 16'(frame_done), 16'h0);
            if (k == 19) begin
                load_valid = 1'b1;
                load_data  = 16'h3CA5;
                load_blank = 4'h0;
            end
            tick();
        end
        load_valid = 1'b0;
        chk("c20 frame_done", 16'(frame_done), 16'h1);
        chk("c20 load_ready", 16'(load_ready), 16'h0);
        for (int k = 20; k < 40; k++) begin
            chk($sformatf("boundary-load c%0d dig_en", k), 16'(dig_en), 16'h0);
            chk($sformatf("boundary-load c%0d dec_val", k), 16'(dec_val), 16'h0);
            tick();
        end
        chk("c40 load_ready", 16'(load_ready), 16'h1);
        run_frame(16'h3CA5, 4'h0, 1'b0, 16'h0, 4'h0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule

// File: doc/display_scan_ctrl.md
DISPLAY_SCAN_CTRL -- requirements
Module: display_scan_ctrl

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 4: number of multiplexed digits, legal range 2..8.
REQ-002 SHALL have parameter SCAN_DIV, default 1000: DRIVE dwell per digit in clk cycles, minimum 1.
REQ-003 SHALL have parameter BLANK_CYC, default 2: dark gap in cycles before each digit (anti-ghosting), minimum 1.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; one clock; reset is synchronous and active-high.
REQ-005 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port load_valid, input, 1 bit: a new display frame is offered.
REQ-007 SHALL have port load_ready, output, 1 bit: the block can accept a frame.
REQ-008 SHALL have port load_data, input, 4*NUM_DIGITS bits: per-digit nibbles, digit 0 in bits [3:0].
REQ-009 SHALL have port load_blank, input, NUM_DIGITS bits: 1 means that digit stays dark; sampled with load_data.
REQ-010 SHALL have port dec_val, output, 4 bits: the nibble fed to the shared seven_seg decoder input.
REQ-011 SHALL have port dig_en, output, NUM_DIGITS bits: one-hot, active-high digit select.
REQ-012 SHALL have port frame_done, output, 1 bit: one-cycle pulse once per completed scan frame.

Function
REQ-013 SHALL hold an active buffer (nibbles plus blank mask) that drives the display, and a one-entry pending buffer with a valid flag.
REQ-014 SHALL drive load_ready = NOT pending_valid; a frame is accepted on a cycle where load_valid AND load_ready are both high.
REQ-015 SHALL keep load_data and load_blank unsampled on any cycle where load_ready is low.
REQ-016 SHALL use an FSM with states BLANK and DRIVE, plus a digit index idx (0..NUM_DIGITS-1) and a dwell counter.
REQ-017 BLANK: SHALL hold for BLANK_CYC cycles with dig_en = 0 and dec_val = active nibble[idx], then go to DRIVE.
REQ-018 DRIVE: SHALL hold for SCAN_DIV cycles with dec_val = active nibble[idx] and dig_en = one-hot(idx), except dig_en = 0 when the active blank bit for idx is set.
REQ-019 At the end of DRIVE, idx SHALL advance modulo NUM_DIGITS and the FSM SHALL return to BLANK.
REQ-020 Frame period SHALL be exactly NUM_DIGITS*(BLANK_CYC+SCAN_DIV) cycles.
REQ-021 At the edge ending DRIVE of idx = NUM_DIGITS-1 (frame boundary):
  - frame_done SHALL be high for the following cycle only.
  - If pending_valid is set, pending SHALL be copied to active and pending_valid cleared at that same edge.
REQ-022 A frame accepted on the boundary cycle itself SHALL land in pending and SHALL be applied at the next boundary; the active buffer never changes mid-frame.
REQ-023 All outputs SHALL be registered.

Reset
REQ-024 On reset (sampled at the clk edge) the block SHALL set:
  - state = BLANK, idx = 0, counters = 0;
  - active nibbles = 0, active blank mask = all ones;
  - pending_valid = 0, which discards any in-flight pending frame;
  - dig_en = 0, dec_val = 0, frame_done = 0, load_ready = 1.
REQ-025 Reset asserted mid-frame SHALL abort the scan; scanning SHALL restart from digit 0 in the cycle after reset deasserts.

Configuration
REQ-026 With macro DISPLAY_SCAN_BLINK_EN defined:
  - the block SHALL add input load_blink (NUM_DIGITS bits, sampled with load_data) and parameter BLINK_FRAMES (default 32);
  - a frame counter SHALL toggle a blink phase every BLINK_FRAMES frames;
  - while the phase is 1, digits whose blink bit is set SHALL behave as blanked;
  - the phase SHALL reset to 0.
REQ-027 Without DISPLAY_SCAN_BLINK_EN, the load_blink port, BLINK_FRAMES and the blink logic SHALL be absent, and behaviour SHALL be exactly REQ-013..025.

Structure
REQ-028 Shared package disp_pkg SHALL hold:
  - the scan_state_t enum (BLANK, DRIVE);
  - the nibble_t typedef (4 bits);
  - the constant DIGITS_MAX = 8.
REQ-029 The dwell counter SHALL be a sub-module scan_timer: loads a terminal count, pulses on expiry.
REQ-030 dec_val SHALL connect externally to seven_seg; the seven_seg decoder SHALL NOT be instantiated inside this block.

Verification (NUM_DIGITS=4, SCAN_DIV=4, BLANK_CYC=1)
REQ-031 Reset then idle 40 cycles -> dig_en stays 0; frame_done pulses at cycles 20 and 40; load_ready = 1 throughout.
REQ-032 Load data 0x4321, blank 0x0 -> from the next boundary, each digit shows 1 BLANK cycle then 4 DRIVE cycles with dig_en 0001/0010/0100/1000 and dec_val 1/2/3/4.
REQ-033 Two loads back-to-back (0x1111, then 0x2222 held valid) -> load_ready drops after the first; the second is accepted only in the cycle after the boundary and is displayed one frame later.
REQ-034 Load 0x9876 with blank 0x4 -> dig_en for digit 2 is 0 for its whole dwell; dec_val still equals 8.
REQ-035 Assert reset mid-DRIVE of digit 2 with pending full -> the next cycle gives dig_en = 0, load_ready = 1, and all digits dark until a new load.
REQ-036 With DISPLAY_SCAN_BLINK_EN and BLINK_FRAMES=2, blink 0x1 -> digit 0 is dark in frames 3-4 and lit in frames 5-6.
